// File: rtl/link_pkg.sv
// link_pkg: link state type and the fixed IDLE/TRAIN words shared by the transmitter
package link_pkg;
  localparam int MAXW = 1024;
  typedef enum logic [1:0] {TRAIN, WAIT, RUN} link_state_t;
  function automatic logic [MAXW-1:0] idle_word(input int w);
    idle_word = '0;
    for (int i = 0; i < w; i++) idle_word[i] = 1'b1;
  endfunction
  function automatic logic [MAXW-1:0] train_word(input int w);
    train_word = '0;
    for (int i = 1; i < w; i += 2) train_word[i] = 1'b1;
  endfunction
endpackage

// File: rtl/link_tx_fifo.sv
// link_tx_fifo: synchronous FIFO buffering words ahead of the link
module link_tx_fifo #(
  parameter int w = 128,
  parameter int D = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [w-1:0]         wdata,
  output logic [w-1:0]         rdata,
  output logic [$clog2(D):0]   count,
  output logic                 empty,
  output logic                 full
);
  localparam int AW = $clog2(D);
  logic [w-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  assign empty = count == '0;
  assign full = count == (AW+1)'(D);
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/link_tx.sv
// link_tx: ring link transmitter that trains until aligned, then streams buffered words
module link_tx
  import link_pkg::*;
#(
  parameter int w = 128,
  parameter int D = 8,
  parameter int TRAIN_LEN = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [w-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic         aligned,
  output logic [w-1:0] odata,
  output logic         ovalid,
  output logic         link_up,
  output logic [15:0]  drop_count
);
  localparam logic [w-1:0] IDLE = w'(idle_word(w));
  localparam logic [w-1:0] TRAINW = w'(train_word(w));
  localparam int CW = $clog2(TRAIN_LEN + 1);
  localparam int AW = $clog2(D);
  link_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] hist, hist_n;
  logic reset_q, push, pop, drop, empty, full;
  logic [w-1:0] rdata;
  logic [AW:0] count;
  assign tx_ready = !reset_q && count < (AW+1)'(D);
  assign drop = tx_valid && tx_ready && tx_data == IDLE;
  assign push = tx_valid && tx_ready && !full && tx_data != IDLE;
  assign pop = state == RUN && !empty;
  link_tx_fifo #(.w(w), .D(D)) fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .wdata(tx_data),
    .rdata(rdata), .count(count), .empty(empty), .full(full)
  );
  // History is shifted before the test so two consecutive aligned samples suffice
  always_comb begin
    state_n = state;
    cnt_n = '0;
    hist_n = '0;
    if (state == TRAIN) begin
      cnt_n = cnt + CW'(1);
      if (cnt == CW'(TRAIN_LEN - 1)) state_n = WAIT;
    end else if (state == WAIT) begin
      hist_n = {hist[0], aligned};
      if (&hist_n) state_n = RUN;
    end else if (!aligned) state_n = TRAIN;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= TRAIN;
      cnt <= '0;
      hist <= '0;
      reset_q <= 1'b1;
      odata <= '0;
      ovalid <= 1'b0;
      link_up <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hist <= hist_n;
      reset_q <= 1'b0;
      odata <= pop ? rdata : state == RUN ? IDLE : TRAINW;
      ovalid <= pop;
      link_up <= state == RUN;
      drop_count <= drop_count + 16'(drop && drop_count != 16'hFFFF);
    end
  end
endmodule

// File: tb/tb_link_tx.sv
// tb_link_tx: scoreboard bench for the ring link transmitter
module tb_link_tx;
  localparam int W = 128, D = 8, TL = 16;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] TRAINW = {(W/2){2'b10}};
  logic clock = 0, reset = 0, tx_valid = 0, aligned = 0;
  logic [W-1:0] tx_data = '0, odata, mon_e;
  logic tx_ready, ovalid, link_up;
  logic [15:0] drop_count;
  logic [W-1:0] exp_q[$];
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  link_tx #(.w(W), .D(D), .TRAIN_LEN(TL)) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .aligned(aligned), .odata(odata), .ovalid(ovalid),
    .link_up(link_up), .drop_count(drop_count)
  );

  always @(negedge clock) if (ovalid === 1'b1) begin
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_word: odata %h, required no payload", odata);
    end else begin
      mon_e = exp_q.pop_front();
      if (odata !== mon_e) begin
        errors++;
        $display("FAIL stream_word: odata %h, required %h", odata, mon_e);
      end
    end
  end

  task automatic push_word(input logic [W-1:0] d);
    int n = 0;
    tx_data = d;
    tx_valid = 1;
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: tx_ready %b, required 1", tx_ready);
    end else begin
      if (d !== ONES) exp_q.push_back(d);
      @(negedge clock);
    end
    tx_valid = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    aligned = 1;
    tx_valid = 1;
    tx_data = W'(32'h55);
    repeat (2) @(negedge clock);
    tx_valid = 0;
    checks++;
    if (odata !== '0 || ovalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: odata %h ovalid %b, required 0 0", odata, ovalid);
    end
    checks++;
    if (link_up !== 1'b0 || drop_count !== 16'h0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: link_up %b drop %h ready %b, required 0 0 0", link_up, drop_count, tx_ready);
    end
  endtask

  task automatic test_train;
    reset = 1;
    for (int i = 1; i <= TL + 2; i++) begin
      @(negedge clock);
      checks++;
      if (odata !== TRAINW || ovalid !== 1'b0 || link_up !== 1'b0) begin
        errors++;
        $display("FAIL train_word %0d: odata %h ovalid %b link_up %b, required %h 0 0", i, odata, ovalid, link_up, TRAINW);
      end
    end
    @(negedge clock);
    checks++;
    if (link_up !== 1'b1 || odata !== ONES || ovalid !== 1'b0) begin
      errors++;
      $display("FAIL link_up: link_up %b odata %h ovalid %b, required 1 %h 0", link_up, odata, ovalid, ONES);
    end
  endtask

  task automatic test_stream;
    logic ev;
    logic [W-1:0] ed;
    for (int i = 1; i <= 7; i++) begin
      if (i <= 5) begin
        tx_data = W'(i);
        tx_valid = 1;
        checks++;
        if (tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready %0d: tx_ready %b, required 1", i, tx_ready);
        end
        exp_q.push_back(W'(i));
      end else tx_valid = 0;
      @(negedge clock);
      ev = i >= 2 && i <= 6;
      ed = ev ? W'(i - 1) : ONES;
      checks++;
      if (ovalid !== ev || odata !== ed) begin
        errors++;
        $display("FAIL stream_timing %0d: odata %h ovalid %b, required %h %b", i, odata, ovalid, ed, ev);
      end
    end
  endtask

  task automatic test_full;
    int n, run;
    reset = 0;
    aligned = 0;
    @(negedge clock);
    reset = 1;
    for (int i = 1; i <= 8; i++) push_word(W'(32'h100 + i));
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: tx_ready %b, required 0", tx_ready);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (tx_ready !== 1'b0 || ovalid !== 1'b0 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: ready %b ovalid %b link_up %b, required 0 0 0", tx_ready, ovalid, link_up);
    end
    fork
      begin
        push_word(W'(32'h109));
        push_word(W'(32'h10a));
      end
      begin
        aligned = 1;
        n = 0;
        while (ovalid !== 1'b1 && n < 40) begin
          @(negedge clock);
          n++;
        end
        run = 0;
        repeat (10) begin
          if (ovalid === 1'b1) run++;
          @(negedge clock);
        end
        checks++;
        if (run != 10) begin
          errors++;
          $display("FAIL full_no_gaps: valid run %0d, required 10", run);
        end
      end
    join
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain: pending %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_idle;
    push_word(ONES);
    push_word(W'(32'h7));
    push_word(ONES);
    repeat (3) @(negedge clock);
    checks++;
    if (drop_count !== 16'd2) begin
      errors++;
      $display("FAIL drop_count: %0d, required 2", drop_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_drain: pending %0d, required 0", exp_q.size());
    end
    force dut.drop_count = 16'hFFFF;
    #1 release dut.drop_count;
    @(negedge clock);
    push_word(ONES);
    @(negedge clock);
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_saturate: %h, required ffff", drop_count);
    end
  endtask

  task automatic test_realign;
    int n;
    fork
      for (int i = 1; i <= 4; i++) push_word(W'(32'h200 + i));
      begin
        n = 0;
        while (!(ovalid === 1'b1 && odata === W'(32'h202)) && n < 20) begin
          @(negedge clock);
          n++;
        end
        if (n >= 20) begin
          checks++;
          errors++;
          $display("FAIL realign_wait: word 2 not seen, odata %h", odata);
        end
        aligned = 0;
        @(negedge clock);
        aligned = 1;
      end
    join
    @(negedge clock);
    checks++;
    if (link_up !== 1'b0 || odata !== TRAINW) begin
      errors++;
      $display("FAIL realign_train: link_up %b odata %h, required 0 %h", link_up, odata, TRAINW);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || link_up !== 1'b1) begin
      errors++;
      $display("FAIL realign_drain: pending %0d link_up %b, required 0 1", exp_q.size(), link_up);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    aligned = 0;
    repeat (2) @(negedge clock);
    for (int i = 1; i <= 3; i++) push_word(W'(32'h300 + i));
    reset = 0;
    @(negedge clock);
    checks++;
    if (odata !== '0 || ovalid !== 1'b0 || link_up !== 1'b0 || drop_count !== 16'h0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: odata %h ovalid %b link_up %b drop %h ready %b, required 0 0 0 0 0", odata, ovalid, link_up, drop_count, tx_ready);
    end
    exp_q.delete();
    reset = 1;
    aligned = 1;
    n = 0;
    repeat (40) begin
      @(negedge clock);
      if (ovalid === 1'b1) n++;
    end
    checks++;
    if (n != 0 || link_up !== 1'b1) begin
      errors++;
      $display("FAIL mid_discard: emitted %0d link_up %b, required 0 1", n, link_up);
    end
  endtask

  initial begin
    test_reset;
    test_train;
    test_stream;
    test_full;
    test_idle;
    test_realign;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
